// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: definitions shared by the FP32 ALU result-side blocks.
//   - FP32 field positions and the all-ones exponent
//   - collector capture FSM state encodings
//   - classification flags struct and a helper that classifies one word
package fp_alu_pkg;

    localparam int         SIGN_BIT = 31;
    localparam int         EXP_MSB  = 30;
    localparam int         EXP_LSB  = 23;
    localparam int         MANT_W   = 23;
    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        B1       = 4'd1,
        B2       = 4'd2,
        B3       = 4'd3,
        WAIT_LOW = 4'd4
    } col_state_e;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [31:0] w);
        fp_class_t         c;
        logic [7:0]        e;
        logic [MANT_W-1:0] m;
        e      = w[EXP_MSB:EXP_LSB];
        m      = w[MANT_W-1:0];
        c.nan  = (e == EXP_ALL1) && (m != '0);
        c.inf  = (e == EXP_ALL1) && (m == '0);
        c.zero = (e == 8'h00)    && (m == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_word_fifo.sv
// fp_word_fifo: synchronous first-word-fall-through FIFO of 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data; dropped when full unless popping too
//   pop        : read request; ignored when empty
//   dout       : head entry (valid while !empty)
//   full/empty : occupancy flags
//   count      : words held, 0..DEPTH
module fp_word_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          wr_en, rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    // A full FIFO still takes a write when the head leaves on the same edge;
    // wptr == rptr then, and the head is read before it is overwritten.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector: reassembles the ALU's byte-serial results into FP32
// words, buffers them, and streams them out with classification flags.
//   clk, rst           : clock, synchronous active-high reset
//   res_byte, res_done : ALU result bytes, LSB first, while res_done is high
//   m_data, m_valid,
//   m_ready            : output word stream (FWFT head of the buffer)
//   m_is_nan/inf/zero  : classification of the head word
//   count              : words buffered
//   frame_err          : one-cycle pulse when a burst ends early
//   overflow, clr_ovf  : sticky dropped-word flag and its clear
module fp_result_collector
    import fp_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       res_byte,
    input  logic             res_done,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_is_nan,
    output logic             m_is_inf,
    output logic             m_is_zero,
    output logic [CNT_W-1:0] count,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clr_ovf
);

    col_state_e  state, state_nxt;
    logic        done_q;
    logic [23:0] asm_q;       // bytes 0..2 of the word in flight
    logic [2:0]  lane_we;     // which byte lane latches res_byte this cycle
    logic        push, abort, pop;
    logic        full, empty;
    logic [31:0] head;
    fp_class_t   cls;

    always_comb begin
        state_nxt = state;
        lane_we   = '0;
        push      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // Only a rising res_done starts a burst.
                if (res_done && !done_q) begin
                    lane_we[0] = 1'b1;
                    state_nxt  = B1;
                end
            end
            B1: begin
                if (res_done) begin lane_we[1] = 1'b1; state_nxt = B2; end
                else          begin abort      = 1'b1; state_nxt = IDLE; end
            end
            B2: begin
                if (res_done) begin lane_we[2] = 1'b1; state_nxt = B3; end
                else          begin abort      = 1'b1; state_nxt = IDLE; end
            end
            B3: begin
                if (res_done) begin push  = 1'b1; state_nxt = WAIT_LOW; end
                else          begin abort = 1'b1; state_nxt = IDLE; end
            end
            WAIT_LOW: begin
                // Surplus done cycles are swallowed silently.
                if (!res_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            asm_q     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_q    <= res_done;
            frame_err <= abort;
            for (int i = 0; i < 3; i++)
                if (lane_we[i]) asm_q[8*i +: 8] <= res_byte;
            if (clr_ovf)
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign pop = m_valid & m_ready;

    // The last byte goes straight into the FIFO, so the word is visible the
    // cycle after the fourth byte.
    fp_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({res_byte, asm_q}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Gate with empty so stale storage never shows after reset.
    assign m_valid   = ~empty;
    assign m_data    = empty ? 32'h0 : head;
    assign cls       = fp_classify(m_data);
    assign m_is_nan  = m_valid & cls.nan;
    assign m_is_inf  = m_valid & cls.inf;
    assign m_is_zero = m_valid & cls.zero;

endmodule

// File: tb/tb_fp_result_collector.sv
module tb_fp_result_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       res_byte;
    logic             res_done;
    logic [31:0]      m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_is_nan, m_is_inf, m_is_zero;
    logic [CNT_W-1:0] count;
    logic             frame_err;
    logic             overflow;
    logic             clr_ovf;

    int chk  = 0;
    int pass = 0;

    always #5 clk = ~clk;

    fp_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_byte  (res_byte),
        .res_done  (res_done),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_is_nan  (m_is_nan),
        .m_is_inf  (m_is_inf),
        .m_is_zero (m_is_zero),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // Advance n edges; outputs are then looked at 1 time unit after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Four bytes LSB first; returns just after the edge that takes byte 3.
    task automatic burst(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            res_done = 1'b1;
            res_byte = w[8*i +: 8];
            cyc(1);
        end
        res_done = 1'b0;
        res_byte = 8'h00;
    endtask

    // Burst plus the one low cycle needed before another can start.
    task automatic burst_g(input logic [31:0] w);
        burst(w);
        cyc(1);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        cyc(DEPTH + 1);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; res_done = 1'b0; res_byte = 8'h00; m_ready = 1'b0; clr_ovf = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk++; if ({m_valid, m_data, count, frame_err, overflow, m_is_nan, m_is_inf, m_is_zero} !== '0)
            $display("FAIL reset_outputs got v=%b d=%h c=%0d fe=%b ov=%b want all 0", m_valid, m_data, count, frame_err, overflow);
        else pass++;
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'h40400000;
        for (int i = 0; i < 3; i++) begin
            res_done = 1'b1; res_byte = w[8*i +: 8];
            cyc(1);
            chk++; if (m_valid !== 1'b0) $display("FAIL single_early_valid byte%0d got %b want 0", i, m_valid);
            else pass++;
        end
        res_byte = w[31:24];
        cyc(1);
        res_done = 1'b0; res_byte = 8'h00;
        chk++; if (m_valid !== 1'b1) $display("FAIL single_latency got valid=%b want 1", m_valid); else pass++;
        chk++; if (m_data !== 32'h40400000) $display("FAIL single_data got %h want 40400000", m_data); else pass++;
        chk++; if ({m_is_nan, m_is_inf, m_is_zero} !== 3'b000)
            $display("FAIL single_flags got %b want 000", {m_is_nan, m_is_inf, m_is_zero});
        else pass++;
        chk++; if (count !== 3'd1) $display("FAIL single_count got %0d want 1", count); else pass++;
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        chk++; if (count !== 3'd0 || m_valid !== 1'b0) $display("FAIL single_pop got c=%0d v=%b want 0 0", count, m_valid);
        else pass++;
    endtask

    task automatic test_back_to_back();
        burst_g(32'h7F800000);
        burst_g(32'h7FC00001);
        chk++; if (count !== 3'd2) $display("FAIL b2b_count got %0d want 2", count); else pass++;
        chk++; if (m_data !== 32'h7F800000 || m_is_inf !== 1'b1 || m_is_nan !== 1'b0)
            $display("FAIL b2b_head_inf got d=%h inf=%b nan=%b want 7f800000 1 0", m_data, m_is_inf, m_is_nan);
        else pass++;
        cyc(2);
        chk++; if (m_data !== 32'h7F800000) $display("FAIL b2b_hold got %h want 7f800000", m_data); else pass++;
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        chk++; if (m_data !== 32'h7FC00001 || m_is_nan !== 1'b1 || m_is_inf !== 1'b0 || count !== 3'd1)
            $display("FAIL b2b_head_nan got d=%h nan=%b inf=%b c=%0d want 7fc00001 1 0 1", m_data, m_is_nan, m_is_inf, count);
        else pass++;
        drain();
    endtask

    task automatic test_abort();
        res_done = 1'b1; res_byte = 8'hAA; cyc(1);
        res_byte = 8'hBB; cyc(1);
        chk++; if (frame_err !== 1'b0) $display("FAIL abort_early got %b want 0", frame_err); else pass++;
        res_done = 1'b0; res_byte = 8'h00;
        cyc(1);
        chk++; if (frame_err !== 1'b1) $display("FAIL abort_pulse got %b want 1", frame_err); else pass++;
        cyc(1);
        chk++; if (frame_err !== 1'b0 || count !== 3'd0)
            $display("FAIL abort_after got fe=%b c=%0d want 0 0", frame_err, count);
        else pass++;
        burst_g(32'h80000000);
        chk++; if (m_data !== 32'h80000000 || m_is_zero !== 1'b1 || count !== 3'd1)
            $display("FAIL abort_next got d=%h zero=%b c=%0d want 80000000 1 1", m_data, m_is_zero, count);
        else pass++;
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) burst_g(32'h10000001 + 32'(i));
        chk++; if (count !== 3'(DEPTH) || overflow !== 1'b1)
            $display("FAIL ovf_state got c=%0d ov=%b want %0d 1", count, overflow, DEPTH);
        else pass++;
        clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
        chk++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else pass++;
        for (int i = 0; i < DEPTH; i++) begin
            chk++; if (m_data !== 32'h10000001 + 32'(i))
                $display("FAIL ovf_order idx%0d got %h want %h", i, m_data, 32'h10000001 + 32'(i));
            else pass++;
            m_ready = 1'b1; cyc(1); m_ready = 1'b0;
        end
        chk++; if (m_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", m_valid); else pass++;
    endtask

    task automatic test_full_pop_wrap();
        logic [31:0] exp_q[$];
        logic [31:0] w, e;
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'h20000000 + 32'(i);
            burst_g(w);
            exp_q.push_back(w);
        end
        // Fifth word arrives while full, with the head leaving on the same edge.
        w = 32'h2000AA55;
        for (int i = 0; i < 3; i++) begin
            res_done = 1'b1; res_byte = w[8*i +: 8]; cyc(1);
        end
        res_byte = w[31:24]; m_ready = 1'b1;
        cyc(1);
        res_done = 1'b0; res_byte = 8'h00; m_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        chk++; if (count !== 3'(DEPTH) || overflow !== 1'b0)
            $display("FAIL fullpop_state got c=%0d ov=%b want %0d 0", count, overflow, DEPTH);
        else pass++;
        cyc(1);
        // Three more fill/drain rounds walk the pointers around several times.
        for (int r = 0; r < 3; r++) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk++; if (m_valid !== 1'b1 || m_data !== e)
                    $display("FAIL wrap_order round%0d got v=%b d=%h want 1 %h", r, m_valid, m_data, e);
                else pass++;
                m_ready = 1'b1; cyc(1); m_ready = 1'b0;
            end
            if (r < 2) begin
                for (int i = 0; i < DEPTH; i++) begin
                    w = 32'h30000000 + 32'(r * 16 + i);
                    burst_g(w);
                    exp_q.push_back(w);
                end
            end
        end
        chk++; if (count !== 3'd0 || overflow !== 1'b0)
            $display("FAIL wrap_end got c=%0d ov=%b want 0 0", count, overflow);
        else pass++;
    endtask

    task automatic test_rst_mid();
        burst_g(32'h12345678);
        res_done = 1'b1; res_byte = 8'h11; cyc(1);
        res_byte = 8'h22; cyc(1);
        // Now in B2; res_done low here would be an abort, but reset wins.
        rst = 1'b1; res_done = 1'b0; res_byte = 8'h00;
        cyc(1);
        rst = 1'b0;
        chk++; if ({m_valid, m_data, count, frame_err, overflow, m_is_nan, m_is_inf, m_is_zero} !== '0)
            $display("FAIL rstmid_outputs got v=%b d=%h c=%0d fe=%b ov=%b want all 0", m_valid, m_data, count, frame_err, overflow);
        else pass++;
        cyc(1);
        chk++; if (frame_err !== 1'b0) $display("FAIL rstmid_no_err got %b want 0", frame_err); else pass++;
        burst_g(32'h3F800000);
        chk++; if (m_data !== 32'h3F800000 || count !== 3'd1 || frame_err !== 1'b0)
            $display("FAIL rstmid_next got d=%h c=%0d fe=%b want 3f800000 1 0", m_data, count, frame_err);
        else pass++;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_overflow();
        test_full_pop_wrap();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
Downstream consumer of the FP32 add/sub ALU's byte-serial result port. It reassembles each 4-byte result burst (LSB first) into a 32-bit word and buffers words in a small FIFO. Words leave on a valid/ready stream toward the host-side logic. It also provides per-word FP32 classification flags and error/overflow status.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, minimum 2
CNT_W, 3, width of the occupancy count; equals log2(DEPTH)+1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
res_byte  input  8  ALU result byte bus
res_done  input  1  ALU done flag; high for exactly 4 cycles per result; res_byte carries bytes 0,1,2,3 on those cycles
m_data  output  32  head word of the FIFO (first-word fall-through)
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts m_data this cycle
m_is_nan  output  1  head has exp==8'hFF and mant!=0
m_is_inf  output  1  head has exp==8'hFF and mant==0
m_is_zero  output  1  head has exp==0 and mant==0 (either sign)
count  output  CNT_W  words currently buffered
frame_err  output  1  one-cycle pulse when a burst is aborted
overflow  output  1  sticky; set when a completed word is dropped because the FIFO is full
clr_ovf  input  1  clears overflow; takes priority over a same-cycle set

Behaviour:
- Reset (rst high at a clk edge): all outputs are 0; FIFO empty, count=0; FSM in IDLE; done_q=0. Reset mid-burst discards any partial word.
- done_q registers res_done every cycle. Burst start is res_done & !done_q.
- Capture FSM (4-bit state):
  - IDLE: on burst start, latch res_byte into bits [7:0] -> B1.
  - B1 / B2: if res_done, latch into [15:8] / [23:16] -> next state. Otherwise pulse frame_err -> IDLE.
  - B3: if res_done, latch into [31:24] and assert push for this cycle -> WAIT_LOW. Otherwise pulse frame_err -> IDLE.
  - WAIT_LOW: stay while res_done is high. When it is low -> IDLE. Any extra high cycles are ignored with no error.
  - A new burst start is recognised only in IDLE.
- Push writes the assembled word, including the byte arriving in B3, into the FIFO. The word is visible on m_data/m_valid the cycle after the B3 edge. Latency is 4 cycles from the first byte's cycle to m_valid high, when the FIFO was empty.
- Pop occurs when m_valid & m_ready. The head advances at the clock edge.
- Push while full:
  - With a same-cycle pop: the push is accepted and count is unchanged.
  - Without a pop: the word is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop together when not full: count is unchanged.
- Pop while empty: no effect.
- Pointers use log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- m_data and the class flags are combinational from the head entry. They are don't-care when m_valid=0.
- While m_valid=1 and m_ready=0, m_data must hold stable.

Decomposition:
- Shared package fp_alu_pkg holds:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23, EXP_ALL1=8'hFF.
  - Collector FSM state encodings: IDLE, B1, B2, B3, WAIT_LOW.
- One sub-module fp_word_fifo: synchronous FWFT FIFO with parameter DEPTH and ports push, pop, din, dout, full, empty, count.

Test Plan:
- Single result 3.0: burst bytes 00,00,40,40 -> m_data=32'h40400000, m_valid rises on the cycle after byte 3, is_nan/inf/zero=0, count=1; m_ready=1 -> count=0.
- Back-to-back bursts 0x7F800000 and 0x7FC00001 with m_ready=0 -> count=2; head shows is_inf=1; after one pop the head shows is_nan=1.
- Aborted burst: res_done high 2 cycles, then low -> frame_err high exactly 1 cycle, count unchanged. A following full burst 0x80000000 -> is_zero=1.
- Overflow: DEPTH+1 bursts with m_ready=0 -> count=DEPTH, overflow=1, FIFO holds the first DEPTH words in order. Then clr_ovf -> overflow=0.
- Full with a simultaneous pop on the push cycle -> new word accepted, count stays DEPTH, overflow stays 0. Pointer wrap is verified over 3*DEPTH words with no reorder.
- rst asserted during B2 -> next cycle all outputs 0. The following burst 0x3F800000 is captured correctly with no frame_err.
